// File: rtl/sram_mem_stage_ctrl_pkg.sv
// Shared types and constants for the 32-bit-over-16-bit SRAM memory-stage controller.
// Also holds the half-word address helper used by the controller.
package sram_mem_stage_ctrl_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam int WORD_W  = 32;
    localparam int WIDX_W  = SRAM_AW - 1;

    localparam logic [WORD_W-1:0] DEFAULT_SRAM_BASE = 32'd1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_LO,
        ST_WR_HI,
        ST_RD_LO,
        ST_RD_HI,
        ST_DONE
    } mem_state_e;

    // A 32-bit word occupies two consecutive half-words: low half at even, high at odd.
    function automatic logic [SRAM_AW-1:0] half_addr(input logic [WIDX_W-1:0] word_idx,
                                                     input logic              hi);
        return {word_idx, hi};
    endfunction

endpackage

// File: rtl/sram_mem_stage_ctrl_wait.sv
// Per-half-access wait counter: clears on state entry, counts while enabled,
// and flags the final cycle of an ACCESS_CYC-long half-access.
module sram_wait_counter #(
    parameter int ACCESS_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    assign term_o = (cnt_q == 3'(ACCESS_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !term_o) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_mem_stage_ctrl.sv
// MEM-stage controller: splits a 32-bit load/store into two 16-bit SRAM accesses
// and holds ready low (pipeline freeze) until the word is complete.
module sram_mem_stage_ctrl
    import sram_mem_stage_ctrl_pkg::*;
#(
    parameter int                ACCESS_CYC = 2,
    parameter logic [WORD_W-1:0] SRAM_BASE  = DEFAULT_SRAM_BASE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [WORD_W-1:0]  address,
    input  logic [WORD_W-1:0]  wdata,
    output logic [WORD_W-1:0]  rdata,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
);

    mem_state_e          state_q, state_d;
    logic [WIDX_W-1:0]   widx_q, widx_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [WORD_W-1:0]   rdata_q, rdata_d;
    logic [SRAM_AW-1:0]  sram_addr_q, sram_addr_d;

    logic [WORD_W-1:0]   offset_in;
    logic [WIDX_W-1:0]   widx_in;
    logic                unused_offset_bits;
    logic                cnt_clr;
    logic                cnt_en;
    logic                cnt_term;
    logic                dq_oe;
    logic [SRAM_DW-1:0]  dq_out;
    logic                we_n;
    logic                ready_c;

    assign offset_in          = address - SRAM_BASE;
    assign widx_in            = offset_in[18:2];
    assign unused_offset_bits = ^{offset_in[WORD_W-1:19], offset_in[1:0]};

    sram_wait_counter #(
        .ACCESS_CYC (ACCESS_CYC)
    ) u_wait (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .term_o (cnt_term)
    );

    always_comb begin
        state_d     = state_q;
        widx_d      = widx_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        we_n        = 1'b1;
        dq_oe       = 1'b0;
        dq_out      = '0;
        cnt_en      = 1'b0;
        ready_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_c = !rd_en && !wr_en;
                // Simultaneous rd_en/wr_en is resolved as a store.
                if (wr_en || rd_en) begin
                    state_d     = wr_en ? ST_WR_LO : ST_RD_LO;
                    widx_d      = widx_in;
                    wdata_d     = wdata;
                    sram_addr_d = half_addr(widx_in, 1'b0);
                end
            end
            ST_WR_LO: begin
                we_n   = 1'b0;
                dq_oe  = 1'b1;
                dq_out = wdata_q[15:0];
                cnt_en = 1'b1;
                if (cnt_term) begin
                    state_d     = ST_WR_HI;
                    sram_addr_d = half_addr(widx_q, 1'b1);
                end
            end
            ST_WR_HI: begin
                we_n   = 1'b0;
                dq_oe  = 1'b1;
                dq_out = wdata_q[31:16];
                cnt_en = 1'b1;
                if (cnt_term) begin
                    state_d = ST_DONE;
                end
            end
            ST_RD_LO: begin
                cnt_en = 1'b1;
                if (cnt_term) begin
                    rdata_d[15:0] = SRAM_DQ;
                    state_d       = ST_RD_HI;
                    sram_addr_d   = half_addr(widx_q, 1'b1);
                end
            end
            ST_RD_HI: begin
                cnt_en = 1'b1;
                if (cnt_term) begin
                    rdata_d[31:16] = SRAM_DQ;
                    state_d        = ST_DONE;
                end
            end
            ST_DONE: begin
                ready_c = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every state entry restarts the half-access timer.
        cnt_clr = (state_d != state_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            widx_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
        end
    end

    assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DW{1'bz}};
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
    assign rdata     = rdata_q;
    assign ready     = ready_c;

endmodule

// File: tb/tb_sram_mem_stage_ctrl.sv
// Scoreboard bench: three lanes (ACCESS_CYC = 1, 2, 7), each with its own SRAM
// model, word-level reference memory, stimulus driver and completion monitor.
module tb_sram_mem_stage_ctrl;

    typedef struct {
        bit          is_wr;
        int          idx;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic clk;
    int   vectors;
    int   miscompares;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input int a, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (A=%0d) t=%0t: got %h, want %h", name, a, $time, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        localparam int A = (gi == 0) ? 1 : (gi == 1) ? 2 : 7;

        logic        rst;
        logic        rd_en;
        logic        wr_en;
        logic [31:0] address;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        ready;
        wire  [15:0] sram_dq;
        logic [17:0] sram_addr;
        logic        we_n, ub_n, lb_n, ce_n, oe_n;
        logic        done;

        logic [15:0] mem [0:262143];
        logic [31:0] ref_mem [int];
        logic [31:0] last_rd;
        exp_t        exp_q[$];

        sram_mem_stage_ctrl #(
            .ACCESS_CYC (A),
            .SRAM_BASE  (32'd1024)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .rd_en     (rd_en),
            .wr_en     (wr_en),
            .address   (address),
            .wdata     (wdata),
            .rdata     (rdata),
            .ready     (ready),
            .SRAM_DQ   (sram_dq),
            .SRAM_ADDR (sram_addr),
            .SRAM_WE_N (we_n),
            .SRAM_UB_N (ub_n),
            .SRAM_LB_N (lb_n),
            .SRAM_CE_N (ce_n),
            .SRAM_OE_N (oe_n)
        );

        // Asynchronous SRAM with OE tied low: drives the bus whenever not writing.
        assign sram_dq = we_n ? mem[sram_addr] : 16'hzzzz;

        initial begin
            for (int i = 0; i < 262144; i++) mem[i] = '0;
            forever begin
                @(posedge clk);
                if (!we_n) mem[sram_addr] = sram_dq;
            end
        end

        function automatic logic [31:0] ref_rd(input int idx);
            return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
        endfunction

        task automatic access(input bit r, input bit w, input logic [31:0] a,
                              input logic [31:0] d);
            exp_t e;
            bit   got;
            e.is_wr = w;
            e.idx   = int'((a - 32'd1024) >> 2);
            e.wdata = d;
            if (w) ref_mem[e.idx] = d;
            else   last_rd = ref_rd(e.idx);
            e.rdata = last_rd;
            exp_q.push_back(e);
            $display("lane A=%0d %s addr=%0d data=%h", A, w ? "store" : "load ", a,
                     w ? d : e.rdata);
            rd_en   = r;
            wr_en   = w;
            address = a;
            wdata   = d;
            got = 1'b0;
            for (int n = 0; n < 64 && !got; n++) begin
                @(negedge clk);
                got = ready;
            end
            if (!got) chk(A, "handshake_timeout", 32'(got), 32'd1);
            @(posedge clk);
            #1;
            rd_en = 1'b0;
            wr_en = 1'b0;
        endtask

        task automatic idle(input int n);
            rd_en = 1'b0;
            wr_en = 1'b0;
            repeat (n) @(posedge clk);
            #1;
        endtask

        // Stimulus driver.
        initial begin
            int          op;
            logic [31:0] ra, rd;
            logic [31:0] w0;
            done    = 1'b0;
            rst     = 1'b1;
            rd_en   = 1'b0;
            wr_en   = 1'b0;
            address = '0;
            wdata   = '0;
            last_rd = '0;
            repeat (3) @(posedge clk);
            #1;
            chk(A, "rst_ready", 32'(ready), 32'd1);
            chk(A, "rst_we_n", 32'(we_n), 32'd1);
            chk(A, "rst_sram_addr", 32'(sram_addr), 32'd0);
            chk(A, "rst_rdata", rdata, 32'd0);
            rst = 1'b0;
            @(posedge clk);
            #1;
            chk(A, "idle_dq_released", 32'(sram_dq), 32'd0);

            access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
            access(1'b1, 1'b0, 32'd1024, 32'h0);
            access(1'b0, 1'b1, 32'd1032, 32'h12345678);
            access(1'b1, 1'b0, 32'd1034, 32'h0);
            idle(1);
            access(1'b1, 1'b0, 32'd1024, 32'h0);
            access(1'b1, 1'b0, 32'd1032, 32'h0);
            idle(2);
            access(1'b1, 1'b1, 32'd1028, 32'hCAFEF00D);
            access(1'b1, 1'b0, 32'd1028, 32'h0);

            for (int i = 0; i < 40; i++) begin
                op = int'($urandom_range(0, 3));
                ra = 32'd1024 + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
                rd = $urandom;
                case (op)
                    0:       access(1'b0, 1'b1, ra, rd);
                    1:       access(1'b1, 1'b0, ra, rd);
                    2:       access(1'b1, 1'b1, ra, rd);
                    default: idle(int'($urandom_range(1, 2)));
                endcase
            end
            idle(1);

            // Store aborted by reset inside the high half.
            $display("lane A=%0d store addr=1824 aborted by reset", A);
            wr_en   = 1'b1;
            address = 32'd1824;
            wdata   = 32'h0BADF00D;
            repeat (A + ((A >= 2) ? 2 : 1)) @(posedge clk);
            #2;
            chk(A, "abort_pre_we_n", 32'(we_n), 32'd0);
            rst = 1'b1;
            #1;
            w0 = ref_rd(0);
            chk(A, "abort_we_n", 32'(we_n), 32'd1);
            chk(A, "abort_sram_addr", 32'(sram_addr), 32'd0);
            chk(A, "abort_rdata", rdata, 32'd0);
            chk(A, "abort_ready_req", 32'(ready), 32'd0);
            chk(A, "abort_dq_released", 32'(sram_dq), 32'(w0[15:0]));
            wr_en = 1'b0;
            #1;
            chk(A, "abort_ready_idle", 32'(ready), 32'd1);
            @(posedge clk);
            #1;
            rst = 1'b0;
            idle(2);
            done = 1'b1;
        end

        // Monitor: per-cycle bus checks while busy, full compare at completion.
        initial begin
            int   k;
            int   c;
            exp_t e;
            k = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    k = 0;
                end else if (rd_en || wr_en) begin
                    if (!ready) begin
                        k++;
                        if (exp_q.size() > 0 && k >= 2) begin
                            c = k - 1;
                            e = exp_q[0];
                            chk(A, "sram_addr", 32'(sram_addr),
                                (c <= A) ? 32'(2 * e.idx) : 32'(2 * e.idx + 1));
                            chk(A, "we_n_busy", 32'(we_n), e.is_wr ? 32'd0 : 32'd1);
                            if (e.is_wr)
                                chk(A, "dq_drive", 32'(sram_dq),
                                    (c <= A) ? 32'(e.wdata[15:0]) : 32'(e.wdata[31:16]));
                        end
                        if (k > 64) begin
                            chk(A, "busy_timeout", 32'(k), 32'd0);
                            k = 0;
                        end
                    end else begin
                        if (exp_q.size() == 0) begin
                            chk(A, "spurious_done", 32'(exp_q.size()), 32'd1);
                        end else begin
                            e = exp_q.pop_front();
                            chk(A, "busy_cycles", 32'(k), 32'(2 * A + 1));
                            chk(A, "rdata", rdata, e.rdata);
                            chk(A, "we_n_done", 32'(we_n), 32'd1);
                            chk(A, "dq_done", 32'(sram_dq),
                                e.is_wr ? 32'(e.wdata[31:16]) : 32'(e.rdata[31:16]));
                            if (e.is_wr) begin
                                chk(A, "mem_lo", 32'(mem[2 * e.idx]), 32'(e.wdata[15:0]));
                                chk(A, "mem_hi", 32'(mem[2 * e.idx + 1]), 32'(e.wdata[31:16]));
                            end
                        end
                        k = 0;
                    end
                end else begin
                    chk(A, "idle_ready", 32'(ready), 32'd1);
                    chk(A, "idle_we_n", 32'(we_n), 32'd1);
                    chk(A, "tied_strobes", 32'({ub_n, lb_n, ce_n, oe_n}), 32'd0);
                    k = 0;
                end
            end
        end
    end

    initial begin
        int t;
        vectors     = 0;
        miscompares = 0;
        t = 0;
        while (!(g_lane[0].done && g_lane[1].done && g_lane[2].done) && t < 30000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 30000) begin
            vectors++;
            miscompares++;
            $display("FAIL global_timeout: lanes done %b%b%b, want 111",
                     g_lane[2].done, g_lane[1].done, g_lane[0].done);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
